decade_scan_ctrl: RTL

DECADE_SCAN_CTRL -- requirements
Module: decade_scan_ctrl

---
 rtl/decade_scan_ctrl_pkg.sv | 32 +++
 rtl/decade_scan_ctrl_bcd_dec10.sv | 26 ++
 rtl/decade_scan_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/decade_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// decade_scan_ctrl_pkg
// Shared definitions for the decade keypad scanner:
//   scanState_e : scanner FSM states (IDLE, SCAN, CONFIRM, HOLD)
//   DIGIT_W     : width of a digit code (BCD, 4 bits)
//   LINE_COUNT  : number of digit lines driven (10)
//   nextDigit() : advance a digit code by one, wrapping 9 back to 0
// ---------------------------------------------------------------------------
package decade_scan_ctrl_pkg;

    localparam int DIGIT_W    = 4;
    localparam int LINE_COUNT = 10;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        CONFIRM,
        HOLD
    } scanState_e;

    // Digits run 0..9 only, so anything at or beyond 9 returns to 0.
    function automatic logic [DIGIT_W-1:0] nextDigit(input logic [DIGIT_W-1:0] digit);
        logic [DIGIT_W-1:0] result;
        if (digit >= DIGIT_W'(LINE_COUNT - 1)) begin
            result = '0;
        end else begin
            result = digit + DIGIT_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/decade_scan_ctrl_bcd_dec10.sv
// ---------------------------------------------------------------------------
// bcd_dec10
// Decodes a 4-bit digit code into ten one-hot, active-high digit lines.
// Codes 10..15 decode to all lines low, so an illegal code never drives
// a line.
// Ports:
//   bcd   : input  [3:0] digit code
//   lines : output [9:0] one-hot line image, lines[bcd] high for bcd 0..9
// ---------------------------------------------------------------------------
module bcd_dec10
    import decade_scan_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0]    bcd,
    output logic [LINE_COUNT-1:0] lines
);

    // Each line compares its own index against the code; codes above 9
    // match no index and leave every line low.
    always_comb begin
        lines = '0;
        for (int i = 0; i < LINE_COUNT; i++) begin
            lines[i] = (bcd == DIGIT_W'(i));
        end
    end

endmodule

// File: rtl/decade_scan_ctrl.sv
// ---------------------------------------------------------------------------
// decade_scan_ctrl
// Scans ten digit lines one at a time, holding each for DWELL cycles, and
// samples the common SENSE return on the last cycle of each dwell. A key is
// accepted after DEB consecutive high samples on the same digit and released
// after DEB consecutive low samples; the scan then moves to the next digit.
// Accepted keys are presented on KEY/VALID until acknowledged; a new key
// arriving before acknowledge raises the sticky OVR flag.
// Parameters:
//   DWELL : cycles each digit line is held active (2..255)
//   DEB   : consecutive equal samples to accept a press or release (1..15)
// Ports:
//   clk   : input        clock, rising edge
//   rst   : input        asynchronous active-high reset
//   en    : input        scan enable, low returns the scanner to idle
//   sense : input        return line, high = key on active line closed
//   ack   : input        consumer acknowledge, clears valid and ovr
//   y     : output [9:0] one-hot digit lines (all low while idle)
//   bcd   : output [3:0] digit currently being driven
//   key   : output [3:0] last accepted key code
//   valid : output       key holds an unacknowledged key
//   ovr   : output       sticky overrun flag
// ---------------------------------------------------------------------------
module decade_scan_ctrl
    import decade_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int DEB   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sense,
    input  logic                  ack,
    output logic [LINE_COUNT-1:0] y,
    output logic [DIGIT_W-1:0]    bcd,
    output logic [DIGIT_W-1:0]    key,
    output logic                  valid,
    output logic                  ovr
);

    localparam int                  DWELL_W    = $clog2(DWELL);
    localparam int                  DEB_W      = $clog2(DEB + 1);
    localparam logic [DWELL_W-1:0]  DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [DEB_W-1:0]    DEB_TARGET = DEB_W'(DEB);

    scanState_e            state;
    scanState_e            stateNext;
    logic [DIGIT_W-1:0]    bcdNext;
    logic [DWELL_W-1:0]    dwellCnt;
    logic [DWELL_W-1:0]    dwellNext;
    logic [DEB_W-1:0]      pressCnt;
    logic [DEB_W-1:0]      pressNext;
    logic [DEB_W-1:0]      relCnt;
    logic [DEB_W-1:0]      relNext;
    logic                  samplePoint;
    logic                  capture;
    logic [LINE_COUNT-1:0] decLines;

    // SENSE only matters on the final cycle of each dwell period, giving the
    // line time to settle after the drive changes.
    assign samplePoint = (dwellCnt == DWELL_LAST);

    bcd_dec10 u_dec (
        .bcd   (bcd),
        .lines (decLines)
    );

    // Idle keeps bcd at 0 for a clean restart, but no line may be driven
    // there, so the decoder output is gated by state.
    assign y = (state == IDLE) ? '0 : decLines;

    // Scan state register: FSM state, current digit and the three counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bcd      <= '0;
            dwellCnt <= '0;
            pressCnt <= '0;
            relCnt   <= '0;
        end else begin
            state    <= stateNext;
            bcd      <= bcdNext;
            dwellCnt <= dwellNext;
            pressCnt <= pressNext;
            relCnt   <= relNext;
        end
    end

    // Next-state logic. The dwell counter free-runs within a digit and is
    // cleared at every sample point, which is exactly where any digit change
    // or state change can happen, so each new digit or state starts its
    // dwell from zero. Dropping en abandons whatever scan was in progress.
    always_comb begin
        stateNext = state;
        bcdNext   = bcd;
        dwellNext = dwellCnt + DWELL_W'(1);
        pressNext = pressCnt;
        relNext   = relCnt;
        capture   = 1'b0;

        if (!en) begin
            stateNext = IDLE;
            bcdNext   = '0;
            dwellNext = '0;
            pressNext = '0;
            relNext   = '0;
        end else begin
            case (state)
                IDLE: begin
                    stateNext = SCAN;
                    bcdNext   = '0;
                    dwellNext = '0;
                    pressNext = '0;
                    relNext   = '0;
                end
                SCAN: begin
                    if (samplePoint) begin
                        dwellNext = '0;
                        if (!sense) begin
                            bcdNext = nextDigit(bcd);
                        end else if (DEB == 1) begin
                            capture   = 1'b1;
                            stateNext = HOLD;
                            relNext   = '0;
                        end else begin
                            stateNext = CONFIRM;
                            pressNext = DEB_W'(1);
                        end
                    end
                end
                CONFIRM: begin
                    if (samplePoint) begin
                        dwellNext = '0;
                        if (sense) begin
                            if (pressCnt + DEB_W'(1) == DEB_TARGET) begin
                                capture   = 1'b1;
                                stateNext = HOLD;
                                pressNext = '0;
                                relNext   = '0;
                            end else begin
                                pressNext = pressCnt + DEB_W'(1);
                            end
                        end else begin
                            stateNext = SCAN;
                            bcdNext   = nextDigit(bcd);
                            pressNext = '0;
                        end
                    end
                end
                HOLD: begin
                    if (samplePoint) begin
                        dwellNext = '0;
                        if (sense) begin
                            relNext = '0;
                        end else if (relCnt + DEB_W'(1) == DEB_TARGET) begin
                            stateNext = SCAN;
                            bcdNext   = nextDigit(bcd);
                            relNext   = '0;
                        end else begin
                            relNext = relCnt + DEB_W'(1);
                        end
                    end
                end
                default: begin
                    stateNext = IDLE;
                    bcdNext   = '0;
                    dwellNext = '0;
                    pressNext = '0;
                    relNext   = '0;
                end
            endcase
        end
    end

    // Key handoff to the consumer. A capture always wins and reloads key;
    // overrun is raised only if the previous key was still pending and not
    // being acknowledged in that same cycle. Without a capture, an
    // acknowledge of a pending key clears both flags. This block ignores en
    // so acknowledges are honoured while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key   <= '0;
            valid <= 1'b0;
            ovr   <= 1'b0;
        end else if (capture) begin
            key   <= bcd;
            valid <= 1'b1;
            if (valid && !ack) begin
                ovr <= 1'b1;
            end else if (valid && ack) begin
                ovr <= 1'b0;
            end
        end else if (ack && valid) begin
            valid <= 1'b0;
            ovr   <= 1'b0;
        end
    end

endmodule
